// File: rtl/dispatch_pkg.sv
// Shared types and constants for the dispatch stage that feeds the exe unit.
// The instruction layout below is the contract between fetch, dispatch and the bench.
package dispatch_pkg;

  localparam int DATA_W  = 10;
  localparam int REG_AW  = 4;
  localparam int OP_W    = 3;
  localparam int CNT_W   = 16;
  localparam int INSTR_W = 2 + OP_W + 3 * REG_AW + DATA_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MAX  = 3'd2,
    OP_MIN  = 3'd3,
    OP_AND  = 3'd4,
    OP_ORR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  localparam int LD_BIT  = 26;
  localparam int OP_MSB  = 25;
  localparam int OP_LSB  = 23;
  localparam int IMM_BIT = 22;
  localparam int RD_MSB  = 21;
  localparam int RD_LSB  = 18;
  localparam int RS0_MSB = 17;
  localparam int RS0_LSB = 14;
  localparam int RS1_MSB = 13;
  localparam int RS1_LSB = 10;
  localparam int K_MSB   = 9;
  localparam int K_LSB   = 0;

  typedef struct packed {
    logic              ld;
    op_e               op;
    logic              imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs0;
    logic [REG_AW-1:0] rs1;
    logic [DATA_W-1:0] k;
  } instr_t;

endpackage

// File: rtl/dispatch_instr_unpack.sv
// Combinational slicer: splits a packed instruction into named fields and
// flags whether the instruction actually reads rs1 (register-register ALU op).
module instr_unpack
  import dispatch_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output instr_t             fields,
  output logic               uses_rs1
);

  always_comb begin
    fields.ld  = instr[LD_BIT];
    fields.op  = op_e'(instr[OP_MSB:OP_LSB]);
    fields.imm = instr[IMM_BIT];
    fields.rd  = instr[RD_MSB:RD_LSB];
    fields.rs0 = instr[RS0_MSB:RS0_LSB];
    fields.rs1 = instr[RS1_MSB:RS1_LSB];
    fields.k   = instr[K_MSB:K_LSB];
    uses_rs1   = !instr[LD_BIT] && !instr[IMM_BIT];
  end

endmodule

// File: rtl/dispatch.sv
// Issue/write-back sequencer in front of exe: ISS register drives exe, WB register
// writes the captured result back through exe's write port one cycle later.
module dispatch
  import dispatch_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [DATA_W-1:0]  i_exe_data,
  output logic [OP_W-1:0]    o_oper,
  output logic [REG_AW-1:0]  o_reg0,
  output logic [REG_AW-1:0]  o_reg1,
  output logic               o_imm,
  output logic [DATA_W-1:0]  o_data,
  output logic [REG_AW-1:0]  o_reg2,
  output logic [DATA_W-1:0]  o_data2,
  output logic [CNT_W-1:0]   o_retired
);

  instr_t            in_f;
  logic              in_uses_rs1;
  logic              hazard;
  logic              accept;

  logic              iss_valid;
  instr_t            iss;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  instr_unpack u_unpack (
    .instr    (i_instr),
    .fields   (in_f),
    .uses_rs1 (in_uses_rs1)
  );

  // Only the instruction in ISS can conflict: anything in WB is written
  // at the same edge the incoming instruction moves into ISS.
  always_comb begin
    hazard = 1'b0;
    if (iss_valid && (iss.rd != '0) && !in_f.ld) begin
      hazard = (in_f.rs0 == iss.rd) || (in_uses_rs1 && (in_f.rs1 == iss.rd));
    end
    o_ready = !i_rst && !hazard;
  end

  assign accept = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      iss_valid <= 1'b0;
    end else begin
      iss_valid <= accept;
      if (accept) begin
        iss <= in_f;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= iss_valid;
      wb_rd    <= iss.rd;
      wb_data  <= iss.ld ? iss.k : i_exe_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_retired <= '0;
    end else if (wb_valid) begin
      o_retired <= o_retired + CNT_W'(1);
    end
  end

  // Loads and bubbles leave exe computing an idle ADD r0,r0.
  always_comb begin
    o_oper  = '0;
    o_reg0  = '0;
    o_reg1  = '0;
    o_imm   = 1'b0;
    o_data  = '0;
    o_reg2  = '0;
    o_data2 = '0;
    if (iss_valid && !iss.ld) begin
      o_oper = iss.op;
      o_reg0 = iss.rs0;
      o_reg1 = iss.rs1;
      o_imm  = iss.imm;
      o_data = iss.k;
    end
    if (wb_valid && (wb_rd != '0)) begin
      o_reg2  = wb_rd;
      o_data2 = wb_data;
    end
  end

endmodule
